// File: rtl/seg_scan_controller.sv
// Multiplexed seven-segment scanner: latches DIGITS hex nibbles plus decimal points,
// scans them one slot per PRESCALE cycles with PWM brightness and leading-zero blanking.
module seg_scan_controller #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 131072,
   parameter int BRIGHT_W = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   hex_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  blank_lz,
   input  logic [BRIGHT_W-1:0]   bright,
   output logic [DIGITS-1:0]     cat,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic                  frame_done
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
   localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

   typedef enum logic {SLOT_OFF, SLOT_ON} slot_e;

   logic [PW-1:0]       pcnt_q, pcnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [4*DIGITS-1:0] hex_q;
   logic [DIGITS-1:0]   dpr_q;
   logic [DIGITS-1:0]   cat_q;
   logic [6:0]          seg_q;
   logic                dp_q, fd_q;

   logic                tick;
   logic [BRIGHT_W-1:0] phase;
   slot_e               slot_d;
   logic [3:0]          nib;
   logic                dsel, blank, allz;

   function automatic logic [6:0] decode(input logic [3:0] h);
      case (h)
         4'h0: decode = 7'b1000000;
         4'h1: decode = 7'b1111001;
         4'h2: decode = 7'b0100100;
         4'h3: decode = 7'b0110000;
         4'h4: decode = 7'b0011001;
         4'h5: decode = 7'b0010010;
         4'h6: decode = 7'b0000010;
         4'h7: decode = 7'b1111000;
         4'h8: decode = 7'b0000000;
         4'h9: decode = 7'b0010000;
         4'hA: decode = 7'b0001000;
         4'hB: decode = 7'b0000011;
         4'hC: decode = 7'b1000110;
         4'hD: decode = 7'b0100001;
         4'hE: decode = 7'b0000110;
         default: decode = 7'b0001110;
      endcase
   endfunction

   assign tick   = (pcnt_q == PMAX);
   assign pcnt_d = tick ? '0 : pcnt_q + 1'b1;
   assign idx_d  = !tick ? idx_q : (idx_q == IMAX) ? '0 : idx_q + 1'b1;
   assign phase  = pcnt_q[PW-1 -: BRIGHT_W];
   assign slot_d = ((&bright) || (phase < bright)) ? SLOT_ON : SLOT_OFF;

   // Walk from the most significant digit down so allz means "this and every higher nibble is zero".
   always_comb begin
      nib   = '0;
      dsel  = 1'b0;
      blank = 1'b0;
      allz  = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         allz = allz & (hex_q[4*i +: 4] == 4'h0);
         if (idx_q == IW'(i)) begin
            nib   = hex_q[4*i +: 4];
            dsel  = dpr_q[i];
            blank = blank_lz && (i != 0) && allz;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pcnt_q <= '0;
         idx_q  <= '0;
         hex_q  <= '0;
         dpr_q  <= '0;
         cat_q  <= '1;
         seg_q  <= 7'h7F;
         dp_q   <= 1'b1;
         fd_q   <= 1'b0;
      end else begin
         pcnt_q <= pcnt_d;
         idx_q  <= idx_d;
         if (load) begin
            hex_q <= hex_in;
            dpr_q <= dp_in;
         end
         cat_q <= (slot_d == SLOT_ON) ? ~(DIGITS'(1) << idx_q) : '1;
         seg_q <= blank ? 7'h7F : decode(nib);
         dp_q  <= ~dsel;
         fd_q  <= tick && (idx_q == IMAX);
      end
   end

   assign cat        = cat_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_done = fd_q;

endmodule

// File: doc/seg_scan_controller.md
# seg_scan_controller

Parametrised multiplexed seven-segment scanner for the adder's result display. It replaces the fixed 4-digit display controller with a single-clock design that scans `DIGITS` digits from a synchronous load register. It adds leading-zero blanking, per-digit decimal points, PWM brightness and a frame-done strobe. It sits between the adder's result/operand registers and the board's common-cathode digit drivers.

## Interface
- `DIGITS`, 4: number of digits scanned; range 1..8.
- `PRESCALE`, 131072: clock cycles per digit slot; power of two, ≥ 2^`BRIGHT_W`.
- `BRIGHT_W`, 4: brightness control width.
- `clock`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `load`  in  1  capture strobe; `hex_in`/`dp_in` sampled on any edge with `load`=1.
- `hex_in`  in  4*DIGITS  nibble i = digit i; digit 0 is rightmost.
- `dp_in`  in  DIGITS  decimal point per digit; 1 = lit.
- `blank_lz`  in  1  1 = suppress leading zeros.
- `bright`  in  BRIGHT_W  duty level; 0 = dark, all-ones = full.
- `cat`  out  DIGITS  digit enables, active-low, one-hot.
- `seg`  out  7  segments a..g on `seg[0]`..`seg[6]`, active-low.
- `dp`  out  1  decimal point, active-low.
- `frame_done`  out  1  one-cycle pulse at end of each full scan.

## Operation
- **Display register** (`4*DIGITS` + `DIGITS` bits):
  - Loaded from `hex_in`/`dp_in` when `load`=1.
  - Holds otherwise.
  - Scanning always reads the register, never the live inputs.
- **Prescaler** `pcnt`:
  - Counts 0..`PRESCALE`-1 and wraps.
  - `tick` is asserted when `pcnt`=`PRESCALE`-1.
- **Digit index** `idx`:
  - On `tick`, advances 0→1→…→`DIGITS`-1→0.
  - `DIGITS`=1: `idx` stays 0.
- **Slot state machine**: ON and OFF, evaluated every cycle from `phase` = top `BRIGHT_W` bits of `pcnt`.
  - ON when `bright` is all-ones, or when `phase` < `bright`.
  - OFF otherwise; `bright`=0 means always OFF.
  - `bright` is sampled live, so a change takes effect on the next cycle.
- **Outputs** (registered):
  - In ON: `cat` = all ones except bit `idx` = 0.
  - In OFF: `cat` = all ones. `seg`/`dp` are still driven with the current digit's pattern.
- **Decode**: standard hex glyphs, active-low.
  - 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110 (written `seg[6:0]`).
- **Leading-zero blanking**: digit i>0 is blanked (`seg`=1111111) when `blank_lz`=1 and nibbles `DIGITS`-1 down to i are all zero.
  - Digit 0 is never blanked.
  - `dp` is unaffected by blanking.
- **`frame_done`**: asserted for the cycle in which `tick`=1 and `idx`=`DIGITS`-1.

## Timing
- **Reset values**: `pcnt`=0, `idx`=0, display register=0, `cat`=all ones, `seg`=1111111, `dp`=1, `frame_done`=0.
- **Output latency**: one cycle from `pcnt`/`idx`/register state to `cat`/`seg`/`dp`.
  - First cycle after reset release: outputs still at reset values.
  - Second cycle: digit 0 is shown if ON.
- **Load**: new data appears on `seg` for the current digit two cycles after the `load` edge (one cycle for the register, one for the output).
  - `load` held high reloads every cycle.
  - Load does not disturb `pcnt`/`idx`.
- **Simultaneous events**: `reset` overrides `load` and `tick`.
  - Reset mid-slot returns everything to reset values immediately, without waiting for the clock.
- **`frame_done` rate**: one pulse every `DIGITS`*`PRESCALE` cycles, coincident with `idx` wrapping to 0.
  - Registered, so it appears on the cycle after `tick`.

## Test plan
- **Reset behaviour**: `reset` pulse mid-scan → outputs immediately `cat`=1111, `seg`=1111111, `dp`=1, `frame_done`=0.
  - After release, digit 0 is shown first.
- **Scan order** (`DIGITS`=4, `PRESCALE`=16, `BRIGHT_W`=2, `bright`=3): load `hex_in`=0x1A80 → per 16-cycle slot:
  - `cat`=1110 / `seg`=1000000
  - `cat`=1101 / `seg`=0000000
  - `cat`=1011 / `seg`=0001000
  - `cat`=0111 / `seg`=1111001
  - `frame_done` pulses once per 64 cycles.
- **Leading-zero blanking**: `hex_in`=0x0000 with `blank_lz`=1 → digits 3..1 `seg`=1111111, digit 0 `seg`=1000000.
  - `hex_in`=0x00F0 → digits 3..2 blank, digit 1 shows F, digit 0 shows 0.
- **Brightness**: `bright`=1 → `cat` is active for 4 of 16 cycles per slot. `bright`=0 → `cat` is never active. `bright`=3 → active for all 16.
- **Load isolation**: change `hex_in` with `load`=0 → display unchanged.
  - Pulse `load` → `seg` updates two cycles later.
  - `dp_in`=0101 → `dp`=0 on digits 0 and 2 only.
